sram_wb_master: RTL and testbench

Wishbone classic initiator that moves blocks of 32-bit words to or from the SRAM Wishbone responder. A command port starts a transfer: a start word address and a word count. A write transfer pulls data from a valid/ready input stream. A read transfer pushes data onto a valid/ready output stream. The block sits between user-side engines (crypto core, test logic) and the SRAM responder. It owns the single-cycle ack handshake, address sequencing and a no-ack timeout.

---
 rtl/sram_wb_master.sv | 164 ++++++++++++++++
 tb/tb_sram_wb_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_master.sv
// Wishbone classic initiator that streams blocks of words between valid/ready
// ports and the SRAM responder, with per-word NEXT gap and a no-ack timeout.
module sram_wb_master #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32,
    parameter int LEN_WD  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [ADDR_WD-1:0]   cmd_addr_i,
    input  logic [LEN_WD-1:0]    cmd_len_i,
    input  logic [DATA_WD-1:0]   wr_data_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic [DATA_WD-1:0]   rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_WD-1:0]   wb_adr_o,
    output logic [DATA_WD-1:0]   wb_dat_o,
    output logic [DATA_WD/8-1:0] wb_sel_o,
    input  logic [DATA_WD-1:0]   wb_dat_i,
    input  logic                 wb_ack_i
);

    localparam int TMO_WD = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_PUSH,
        S_NEXT,
        S_ABORT
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_WD-1:0]   addr_q,  addr_d;
    logic [LEN_WD-1:0]    len_q,   len_d;
    logic                 we_q,    we_d;
    logic [TMO_WD-1:0]    tmo_q,   tmo_d;
    logic [DATA_WD-1:0]   wdat_q,  wdat_d;
    logic [DATA_WD-1:0]   rdat_q,  rdat_d;
    logic                 done_q,  done_d;
    logic                 err_q,   err_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            tmo_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every next-state signal is defaulted before the case statement so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        we_d    = we_q;
        tmo_d   = tmo_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    we_d    = cmd_write_i;
                    tmo_d   = '0;
                    state_d = cmd_write_i ? S_FETCH : S_REQ;
                end
            end
            S_FETCH: begin
                if (wr_valid_i) begin
                    wdat_d  = wr_data_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 1'b1;
                // An ack on the final allowed cycle still completes the word.
                if (wb_ack_i) begin
                    if (we_q) begin
                        state_d = S_NEXT;
                    end else begin
                        rdat_d  = wb_dat_i;
                        state_d = S_PUSH;
                    end
                end else if (tmo_q == TMO_WD'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end
            end
            S_PUSH: begin
                if (rd_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                tmo_d = '0;
                if (len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    len_d   = len_q - 1'b1;
                    state_d = we_q ? S_FETCH : S_REQ;
                end
            end
            S_ABORT: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign wr_ready_o  = (state_q == S_FETCH);
    assign rd_valid_o  = (state_q == S_PUSH);
    assign wb_cyc_o    = (state_q == S_REQ);
    assign wb_stb_o    = (state_q == S_REQ);
    assign wb_we_o     = (state_q == S_REQ) && we_q;
    assign wb_adr_o    = addr_q;
    assign wb_dat_o    = wdat_q;
    assign wb_sel_o    = '1;
    assign rd_data_o   = rdat_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sram_wb_master.sv
// Directed bench for sram_wb_master with a one-cycle-latency SRAM responder model.
module tb_sram_wb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [8:0]  cmd_addr_i, cmd_len_i;
    logic [31:0] wr_data_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o, rd_ready_i;
    logic        busy_o, done_o, err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [8:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    always #5 clk = ~clk;

    sram_wb_master #(
        .ADDR_WD(9), .DATA_WD(32), .LEN_WD(9), .TIMEOUT(15)
    ) dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    // Responder: acks one cycle after strobe rises, ack lasts one cycle.
    logic [31:0] mem [512];
    logic        ack_q;
    bit          ack_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= wb_cyc_o && wb_stb_o && !ack_q && ack_en;
            if (wb_stb_o && wb_we_o && !ack_q && ack_en)
                mem[wb_adr_o] <= wb_dat_o;
        end
    end

    assign wb_ack_i = ack_q;
    assign wb_dat_i = mem[wb_adr_o];

    // Bus/stream monitor, sampled mid-cycle.
    int          stb_cycles, gap_bad, done_cnt, rv_cycles;
    bit          prev_ack;
    logic [8:0]  adr_log[$];
    logic        we_log[$];
    logic [3:0]  sel_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] rd_log[$];

    always @(negedge clk) begin
        if (wb_stb_o) stb_cycles++;
        if (prev_ack && wb_stb_o) gap_bad++;
        prev_ack = wb_stb_o && wb_ack_i;
        if (wb_stb_o && wb_ack_i) begin
            adr_log.push_back(wb_adr_o);
            we_log.push_back(wb_we_o);
            sel_log.push_back(wb_sel_o);
            wd_log.push_back(wb_dat_o);
        end
        if (rd_valid_o) rv_cycles++;
        if (rd_valid_o && rd_ready_i) rd_log.push_back(rd_data_o);
        if (done_o) done_cnt++;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wbuf [8];
    int          widx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [8:0] a, input logic [8:0] l);
        cmd_write_i = we;
        cmd_addr_i  = a;
        cmd_len_i   = l;
        cmd_valid_i = 1'b1;
        check("cmd_ready_before_accept", 32'(cmd_ready_o), 32'd1);
        tick;
        cmd_valid_i = 1'b0;
    endtask

    // Counts edges after the accept edge until done_o, feeding the write stream.
    task automatic wait_done(output int n, output logic err_seen);
        logic hs;
        logic to;
        n = 0;
        err_seen = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            hs = wr_ready_o && wr_valid_i;
            if (done_o) begin
                to = 1'b0;
                err_seen = err_o;
                break;
            end
            tick;
            n++;
            if (hs && widx < 7) begin
                widx++;
                wr_data_i = wbuf[widx];
            end
        end
        check("done_within_bound", 32'(to), 32'd0);
    endtask

    int   n, base_a, base_r, base_g, base_d, base_s, base_v;
    logic e, found;

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        wr_data_i = '0; wr_valid_i = 1'b0; rd_ready_i = 1'b0;
        ack_en = 1'b1;
        widx = 0;
        tick;
        tick;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_stb",       32'(wb_stb_o),    32'd0);
        check("rst_cyc",       32'(wb_cyc_o),    32'd0);
        check("rst_we",        32'(wb_we_o),     32'd0);
        check("rst_adr",       32'(wb_adr_o),    32'd0);
        check("rst_dat_o",     wb_dat_o,         32'd0);
        check("rst_rd_data",   rd_data_o,        32'd0);
        check("rst_rd_valid",  32'(rd_valid_o),  32'd0);
        check("rst_wr_ready",  32'(wr_ready_o),  32'd0);
        check("rst_done",      32'(done_o),      32'd0);
        check("rst_err",       32'(err_o),       32'd0);
        rst_n = 1'b1;
        tick;

        // Write 4 words 0xA0..0xA3 to 0x010..0x013.
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
        widx = 0; wr_data_i = wbuf[0]; wr_valid_i = 1'b1;
        base_a = adr_log.size(); base_g = gap_bad; base_d = done_cnt;
        send_cmd(1'b1, 9'h010, 9'd3);
        wait_done(n, e);
        check("wr_done_latency", 32'(n), 32'd16);
        check("wr_err",          32'(e), 32'd0);
        check("wr_ack_count",    32'(adr_log.size() - base_a), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("wr_adr", 32'(adr_log[base_a+k]), 32'h10 + 32'(k));
            check("wr_we",  32'(we_log[base_a+k]),  32'd1);
            check("wr_sel", 32'(sel_log[base_a+k]), 32'hF);
            check("wr_dat", wd_log[base_a+k],       32'hA0 + 32'(k));
        end
        check("wr_next_gap", 32'(gap_bad - base_g), 32'd0);
        wr_valid_i = 1'b0;
        tick;
        check("wr_done_one_cycle", 32'(done_o), 32'd0);
        check("wr_done_count",     32'(done_cnt - base_d), 32'd1);

        // Read the block back with the sink always ready.
        rd_ready_i = 1'b1;
        base_r = rd_log.size(); base_v = rv_cycles; base_g = gap_bad;
        send_cmd(1'b0, 9'h010, 9'd3);
        wait_done(n, e);
        check("rd_done_latency", 32'(n), 32'd16);
        check("rd_err",          32'(e), 32'd0);
        check("rd_word_count",   32'(rd_log.size() - base_r), 32'd4);
        for (int k = 0; k < 4; k++)
            check("rd_data", rd_log[base_r+k], 32'hA0 + 32'(k));
        check("rd_valid_cycles", 32'(rv_cycles - base_v), 32'd4);
        check("rd_next_gap",     32'(gap_bad - base_g), 32'd0);
        tick;

        // Address wrap: write then read two words starting at 0x1FF.
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
        widx = 0; wr_data_i = wbuf[0]; wr_valid_i = 1'b1;
        send_cmd(1'b1, 9'h1FF, 9'd1);
        wait_done(n, e);
        wr_valid_i = 1'b0;
        tick;
        base_a = adr_log.size(); base_r = rd_log.size();
        send_cmd(1'b0, 9'h1FF, 9'd1);
        wait_done(n, e);
        check("wrap_adr0",  32'(adr_log[base_a]),   32'h1FF);
        check("wrap_adr1",  32'(adr_log[base_a+1]), 32'h000);
        check("wrap_data0", rd_log[base_r],   32'hB0);
        check("wrap_data1", rd_log[base_r+1], 32'hB1);
        tick;

        // Read sink stalls for 5 cycles: data held, no strobe.
        rd_ready_i = 1'b0;
        send_cmd(1'b0, 9'h012, 9'd0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_valid_o) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        check("stall_valid_seen", 32'(found), 32'd1);
        check("stall_data",       rd_data_o,  32'hA2);
        base_s = stb_cycles;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("stall_valid_held", 32'(rd_valid_o), 32'd1);
            check("stall_data_held",  rd_data_o,       32'hA2);
        end
        check("stall_no_strobe", 32'(stb_cycles - base_s), 32'd0);
        rd_ready_i = 1'b1;
        wait_done(n, e);
        check("stall_err", 32'(e), 32'd0);
        tick;

        // No ack: strobe for exactly 15 cycles, then done+err.
        ack_en = 1'b0;
        base_s = stb_cycles;
        send_cmd(1'b0, 9'h020, 9'd0);
        wait_done(n, e);
        check("tmo_done_latency", 32'(n), 32'd16);
        check("tmo_err_with_done", 32'(e), 32'd1);
        check("tmo_strobe_cycles", 32'(stb_cycles - base_s), 32'd15);
        tick;
        check("tmo_err_one_cycle", 32'(err_o),       32'd0);
        check("tmo_idle_busy",     32'(busy_o),      32'd0);
        check("tmo_idle_ready",    32'(cmd_ready_o), 32'd1);
        ack_en = 1'b1;

        // Reset while in REQ.
        send_cmd(1'b0, 9'h010, 9'd3);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wb_stb_o) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        check("rst_mid_in_req", 32'(found), 32'd1);
        base_d = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stb",   32'(wb_stb_o),    32'd0);
        check("rst_mid_cyc",   32'(wb_cyc_o),    32'd0);
        check("rst_mid_busy",  32'(busy_o),      32'd0);
        check("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        check("rst_mid_no_done", 32'(done_cnt - base_d), 32'd0);
        base_r = rd_log.size();
        send_cmd(1'b0, 9'h011, 9'd0);
        wait_done(n, e);
        check("post_rst_latency", 32'(n), 32'd4);
        check("post_rst_err",     32'(e), 32'd0);
        check("post_rst_count",   32'(rd_log.size() - base_r), 32'd1);
        if (rd_log.size() > base_r)
            check("post_rst_data", rd_log[base_r], 32'hA1);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
